delay_sched: RTL and testbench

DELAY_SCHED -- requirements
Module: delay_sched

---
 rtl/delay_sched.sv | 187 ++++++++++++++++++
 tb/tb_delay_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_sched.sv
// delay_sched: two-requester front end for an external tapped delay line.
// Arbitrates req0/req1 round-robin into the delay line input, tracks each
// word's requester through a tag pipeline that mirrors the delay line, and
// retargets the tap position only after the line has drained empty.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   req{0,1}_valid/data : requester words offered
//   req{0,1}_ready      : grant; transfer when valid && ready
//   cfg_valid/cfg_pos   : tap-position change request (handshake on cfg_ready)
//   cfg_done, cfg_err   : one-cycle completion / rejection pulses
//   dl_data_in          : word written into the delay line (0 when idle)
//   dl_in_pos           : delay line tap position (latency in cycles)
//   dl_data_out         : delay line output word
//   out_valid/id/data   : delayed word, its requester and its data
//   inflight            : words currently inside the delay line
//
// DEPTH must be in 2..255 so stage indices and positions fit in 8 bits.

module delay_sched #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             cfg_valid,
  input  logic [7:0]       cfg_pos,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [WIDTH-1:0] dl_data_in,
  output logic [7:0]       dl_in_pos,
  input  logic [WIDTH-1:0] dl_data_out,
  output logic             out_valid,
  output logic             out_id,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       inflight
);

  localparam int unsigned PW = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_q;        // 1: req1 was granted last
  logic [PW-1:0]   pos_q;
  logic [PW-1:0]   pend_q;
  logic [PW-1:0]   inflight_q;
  logic            done_q, err_q;
  logic [DEPTH-1:0] tag_vld_q, tag_id_q;
  logic [DEPTH-1:0] tag_vld_d, tag_id_d;

  logic            cfg_legal;
  logic            arb_en;
  logic            pend_ld;
  logic            err_d, done_d;
  logic            gnt0, gnt1, xfer;
  logic [PW-1:0]   ins_idx;

  // Legal tap positions are 1..DEPTH; compare one bit wider to cover DEPTH=255.
  assign cfg_legal = (cfg_pos != '0) && ({1'b0, cfg_pos} <= 9'(DEPTH));

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    pend_ld = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (cfg_valid) begin
          if (cfg_legal) begin
            pend_ld = 1'b1;
            state_d = DRAIN;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          arb_en = 1'b1;
        end
      end
      DRAIN: begin
        // Line is empty: the tap may move without corrupting any word.
        if (inflight_q == '0) begin
          state_d = APPLY;
          done_d  = 1'b1;
        end
      end
      APPLY: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Round-robin grant; uses only valids, state and pointer. Gated by reset so
  // nothing is granted while reset is held.
  assign gnt0 = reset & arb_en & req0_valid & (~req1_valid | last_q);
  assign gnt1 = reset & arb_en & req1_valid & (~req0_valid | ~last_q);
  assign xfer = gnt0 | gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign cfg_ready  = (state_q == RUN);

  assign dl_data_in = gnt0 ? req0_data :
                      gnt1 ? req1_data : '0;

  // Tag insertion point matches the delay line tap: DEPTH - dl_in_pos.
  assign ins_idx = PW'(DEPTH) - pos_q;

  // Tag pipeline: shift toward the output, overwrite the insertion stage.
  always_comb begin
    tag_vld_d = {tag_vld_q[DEPTH-2:0], 1'b0};
    tag_id_d  = {tag_id_q[DEPTH-2:0], 1'b0};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ins_idx == PW'(i)) begin
        tag_vld_d[i] = xfer;
        tag_id_d[i]  = gnt1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= 1'b1;
      pos_q      <= PW'(1);
      pend_q     <= PW'(1);
      inflight_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      done_q    <= done_d;
      err_q     <= err_d;
      if (xfer) begin
        last_q <= gnt1;
      end
      if (pend_ld) begin
        pend_q <= cfg_pos;
      end
      if (state_q == APPLY) begin
        pos_q <= pend_q;
      end
      case ({xfer, tag_vld_q[DEPTH-1]})
        2'b10:   inflight_q <= inflight_q + PW'(1);
        2'b01:   inflight_q <= inflight_q - PW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign out_valid = tag_vld_q[DEPTH-1];
  assign out_id    = tag_id_q[DEPTH-1];
  assign out_data  = tag_vld_q[DEPTH-1] ? dl_data_out : '0;
  assign dl_in_pos = pos_q;
  assign inflight  = inflight_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_delay_sched.sv
// Directed testbench for delay_sched with a behavioural tapped delay line
// (8 stages, word written at stage 8 - dl_in_pos, output from stage 7) that
// shares the DUT reset net.

module tb_delay_sched;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        cfg_valid;
  logic [7:0]  cfg_pos;
  logic        cfg_ready, cfg_done, cfg_err;
  logic [31:0] dl_data_in;
  logic [7:0]  dl_in_pos;
  logic [31:0] dl_data_out;
  logic        out_valid, out_id;
  logic [31:0] out_data;
  logic [7:0]  inflight;

  int checks;
  int errors;

  delay_sched #(.DEPTH(8), .WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .cfg_valid  (cfg_valid),
    .cfg_pos    (cfg_pos),
    .cfg_ready  (cfg_ready),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .dl_data_in (dl_data_in),
    .dl_in_pos  (dl_in_pos),
    .dl_data_out(dl_data_out),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .out_data   (out_data),
    .inflight   (inflight)
  );

  // External delay line model.
  logic [31:0] dl [0:7];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) dl[i] <= '0;
    end else begin
      dl[0] <= (int'(dl_in_pos) == 8) ? dl_data_in : 32'h0;
      for (int i = 1; i < 8; i++) begin
        dl[i] <= (int'(dl_in_pos) == 8 - i) ? dl_data_in : dl[i-1];
      end
    end
  end
  assign dl_data_out = dl[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data  = '0;   req1_data  = '0;
    cfg_valid  = 1'b0; cfg_pos    = '0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Outputs while reset is held, with requesters trying to send.
  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'hDEAD_BEEF;
    req1_valid = 1'b1; req1_data = 32'hCAFE_F00D;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b exp 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got %b exp 0", req1_ready); end
    checks++; if (dl_data_in !== 32'h0) begin errors++; $display("FAIL reset_dl_data_in got %h exp 0", dl_data_in); end
    checks++; if (dl_in_pos !== 8'd1) begin errors++; $display("FAIL reset_dl_in_pos got %0d exp 1", dl_in_pos); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready); end
    checks++; if ({cfg_done, cfg_err, out_valid, out_id} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {cfg_done, cfg_err, out_valid, out_id}); end
    checks++; if (out_data !== 32'h0 || inflight !== 8'd0) begin errors++; $display("FAIL reset_out got data %h inflight %0d exp 0/0", out_data, inflight); end
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Single word from req0 at dl_in_pos=1.
  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'hA5A5_A5A5;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_grant got %b%b exp 10", req0_ready, req1_ready); end
    checks++; if (dl_data_in !== 32'hA5A5_A5A5) begin errors++; $display("FAIL single_dl_data_in got %h exp a5a5a5a5", dl_data_in); end
    @(negedge clk);
    req0_valid = 1'b0; req0_data = '0;
    #1;
    checks++; if (dl_data_in !== 32'h0) begin errors++; $display("FAIL single_dl_idle got %h exp 0", dl_data_in); end
    checks++; if (out_valid !== 1'b1 || out_id !== 1'b0) begin errors++; $display("FAIL single_out got v=%b id=%b exp v=1 id=0", out_valid, out_id); end
    checks++; if (out_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL single_out_data got %h exp a5a5a5a5", out_data); end
    checks++; if (inflight !== 8'd1) begin errors++; $display("FAIL single_inflight got %0d exp 1", inflight); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || inflight !== 8'd0) begin errors++; $display("FAIL single_after got v=%b d=%h n=%0d exp 0/0/0", out_valid, out_data, inflight); end
  endtask

  // Both requesters valid for 4 cycles from reset: grants 0,1,0,1.
  task automatic test_back_to_back();
    logic        exp1;
    logic        prev1;
    logic [31:0] exp_d;
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req0_valid = (k < 4); req0_data = 32'h0000_00A0 + 32'(k);
      req1_valid = (k < 4); req1_data = 32'h0000_00B0 + 32'(k);
      #1;
      exp1 = (k % 2) == 1;
      if (k < 4) begin
        checks++; if (req0_ready !== ~exp1 || req1_ready !== exp1) begin errors++; $display("FAIL rr_grant_%0d got %b%b exp %b%b", k, req0_ready, req1_ready, ~exp1, exp1); end
      end
      if (k >= 1) begin
        prev1 = ((k - 1) % 2) == 1;
        exp_d = prev1 ? 32'h0000_00B0 + 32'(k - 1) : 32'h0000_00A0 + 32'(k - 1);
        checks++; if (out_valid !== 1'b1 || out_id !== prev1 || out_data !== exp_d) begin errors++; $display("FAIL rr_out_%0d got v=%b id=%b d=%h exp v=1 id=%b d=%h", k, out_valid, out_id, out_data, prev1, exp_d); end
        checks++; if (inflight !== 8'd1) begin errors++; $display("FAIL rr_inflight_%0d got %0d exp 1", k, inflight); end
      end
    end
    clear_inputs();
  endtask

  // Tap 1 -> 4 on an empty line, 3 words in flight, then tap 4 -> 5 with a
  // simultaneous req0 request that must wait until after APPLY.
  task automatic test_cfg_drain();
    logic [31:0] exp_d;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_pos = 8'd4;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg4_ready got %b exp 1", cfg_ready); end
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b0 || cfg_done !== 1'b0) begin errors++; $display("FAIL cfg4_drain got rdy=%b done=%b exp 0/0", cfg_ready, cfg_done); end
    @(negedge clk);
    #1;
    checks++; if (cfg_done !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg4_apply got done=%b rdy=%b exp 1/0", cfg_done, cfg_ready); end
    // Three words W0..W2 back to back at tap 4.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_data = 32'h11 * 32'(k + 1);
      #1;
      if (k == 0) begin
        checks++; if (dl_in_pos !== 8'd4 || cfg_done !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg4_run got pos=%0d done=%b rdy=%b exp 4/0/1", dl_in_pos, cfg_done, cfg_ready); end
      end
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL cfg4_send_%0d got %b exp 1", k, req0_ready); end
    end
    // Config and req0 offered together: config wins.
    @(negedge clk);
    cfg_valid = 1'b1; cfg_pos = 8'd5;
    req0_valid = 1'b1; req0_data = 32'h44;
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL cfg5_priority got %b%b exp 00", req0_ready, req1_ready); end
    checks++; if (inflight !== 8'd3) begin errors++; $display("FAIL cfg5_inflight got %0d exp 3", inflight); end
    // Cycles 7..11 relative to the first send: drain W0..W2, then APPLY.
    for (int c = 7; c <= 11; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      #1;
      exp_d = (c >= 7 && c <= 9) ? 32'h11 * 32'(c - 6) : 32'h0;
      checks++; if (out_valid !== (c >= 7 && c <= 9) || out_data !== exp_d) begin errors++; $display("FAIL drain_out_%0d got v=%b d=%h exp d=%h", c, out_valid, out_data, exp_d); end
      checks++; if (inflight !== 8'((c <= 10) ? 10 - c : 0)) begin errors++; $display("FAIL drain_inflight_%0d got %0d exp %0d", c, inflight, (c <= 10) ? 10 - c : 0); end
      checks++; if (cfg_done !== (c == 11) || req0_ready !== 1'b0 || cfg_ready !== 1'b0) begin errors++; $display("FAIL drain_ctrl_%0d got done=%b r0=%b crdy=%b", c, cfg_done, req0_ready, cfg_ready); end
    end
    @(negedge clk);
    #1;
    checks++; if (dl_in_pos !== 8'd5 || req0_ready !== 1'b1) begin errors++; $display("FAIL cfg5_resume got pos=%0d r0=%b exp 5/1", dl_in_pos, req0_ready); end
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      req0_valid = 1'b0; req0_data = '0;
      #1;
      checks++; if (out_valid !== (n == 5)) begin errors++; $display("FAIL lat5_valid_%0d got %b exp %b", n, out_valid, (n == 5)); end
      if (n == 5) begin
        checks++; if (out_data !== 32'h44 || out_id !== 1'b0) begin errors++; $display("FAIL lat5_data got %h id=%b exp 44 id=0", out_data, out_id); end
      end
    end
    clear_inputs();
  endtask

  // Illegal tap positions 0 and 9 are rejected without disturbing traffic.
  task automatic test_cfg_err();
    @(negedge clk);
    cfg_valid = 1'b1; cfg_pos = 8'd0;
    req1_valid = 1'b1; req1_data = 32'h55;
    #1;
    checks++; if (req1_ready !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL err0_hold got r1=%b crdy=%b exp 0/1", req1_ready, cfg_ready); end
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    checks++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || dl_in_pos !== 8'd5) begin errors++; $display("FAIL err0_pulse got err=%b crdy=%b pos=%0d exp 1/1/5", cfg_err, cfg_ready, dl_in_pos); end
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL err0_traffic got %b exp 1", req1_ready); end
    @(negedge clk);
    cfg_valid = 1'b1; cfg_pos = 8'd9;
    req1_data = 32'h66;
    #1;
    checks++; if (cfg_err !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL err9_hold got err=%b r1=%b exp 0/0", cfg_err, req1_ready); end
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    checks++; if (cfg_err !== 1'b1 || dl_in_pos !== 8'd5 || req1_ready !== 1'b1) begin errors++; $display("FAIL err9_pulse got err=%b pos=%0d r1=%b exp 1/5/1", cfg_err, dl_in_pos, req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0; req1_data = '0;
    #1;
    checks++; if (cfg_err !== 1'b0 || cfg_done !== 1'b0) begin errors++; $display("FAIL err_clear got err=%b done=%b exp 0/0", cfg_err, cfg_done); end
    // 0x55 sent at step 1 and 0x66 at step 3 emerge at steps 6 and 8.
    for (int m = 5; m <= 8; m++) begin
      @(negedge clk);
      #1;
      checks++; if (out_valid !== (m == 6 || m == 8) || out_data !== ((m == 6) ? 32'h55 : (m == 8) ? 32'h66 : 32'h0)) begin errors++; $display("FAIL err_out_%0d got v=%b d=%h", m, out_valid, out_data); end
      if (m == 6 || m == 8) begin
        checks++; if (out_id !== 1'b1) begin errors++; $display("FAIL err_out_id_%0d got %b exp 1", m, out_id); end
      end
    end
  endtask

  // Reset during DRAIN aborts the pending tap change.
  task automatic test_reset_drain();
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'h77;
    @(negedge clk);
    req0_valid = 1'b0; cfg_valid = 1'b1; cfg_pos = 8'd2;
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b0 || inflight !== 8'd1) begin errors++; $display("FAIL rd_drain got crdy=%b n=%0d exp 0/1", cfg_ready, inflight); end
    #2;
    reset = 1'b0;
    req0_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0 || inflight !== 8'd0 || out_valid !== 1'b0 || dl_data_in !== 32'h0) begin errors++; $display("FAIL rd_zero got r0=%b n=%0d v=%b d=%h", req0_ready, inflight, out_valid, dl_data_in); end
    checks++; if (cfg_ready !== 1'b1 || dl_in_pos !== 8'd1) begin errors++; $display("FAIL rd_defaults got crdy=%b pos=%0d exp 1/1", cfg_ready, dl_in_pos); end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      #1;
      checks++; if (cfg_done !== 1'b0 || dl_in_pos !== 8'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL rd_after_%0d got done=%b pos=%0d v=%b exp 0/1/0", n, cfg_done, dl_in_pos, out_valid); end
    end
  endtask

  // Tap = DEPTH (8): maximum latency.
  task automatic test_max_depth();
    @(negedge clk);
    cfg_valid = 1'b1; cfg_pos = 8'd8;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL max_done got %b exp 1", cfg_done); end
    @(negedge clk);
    req1_valid = 1'b1; req1_data = 32'h88;
    #1;
    checks++; if (dl_in_pos !== 8'd8 || req1_ready !== 1'b1) begin errors++; $display("FAIL max_send got pos=%0d r1=%b exp 8/1", dl_in_pos, req1_ready); end
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      req1_valid = 1'b0; req1_data = '0;
      #1;
      checks++; if (out_valid !== (n == 8) || out_data !== ((n == 8) ? 32'h88 : 32'h0)) begin errors++; $display("FAIL max_lat_%0d got v=%b d=%h", n, out_valid, out_data); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_cfg_drain();
    test_cfg_err();
    test_reset_drain();
    test_max_depth();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
